// File: rtl/sat_bin_load_ctrl.sv
// sat_bin_load_ctrl: owns the sat_bin external load ports for one problem at a time.
// Resets sat_bin, streams clause and var words from host FIFOs into the four sat_bin RAMs,
// issues start with the bin info, then waits for done and latches the result.
// Optional build macro SAT_BIN_LOAD_WATCHDOG_EN adds a WDOG_CYCLES timeout on LOAD and RUN.
module sat_bin_load_ctrl #(
  parameter int unsigned NUM_CLAUSES_A_BIN = 8,
  parameter int unsigned NUM_VARS_A_BIN    = 8,
  parameter int unsigned WIDTH_CLAUSES     = 16,
  parameter int unsigned WIDTH_VAR         = 12,
  parameter int unsigned WIDTH_VAR_STATES  = 19,
  parameter int unsigned WIDTH_LVL_STATES  = 11,
  parameter int unsigned ADDR_WIDTH        = 9
`ifdef SAT_BIN_LOAD_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES       = 65535
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start_i,
  input  logic [WIDTH_CLAUSES-1:0]    nb_i,
  input  logic [WIDTH_VAR-1:0]        nv_i,
  input  logic                        c_valid_i,
  input  logic [WIDTH_CLAUSES-1:0]    c_data_i,
  output logic                        c_ready_o,
  input  logic                        v_valid_i,
  input  logic [WIDTH_VAR-1:0]        v_data_i,
  output logic                        v_ready_o,
  output logic                        sb_rst_n_o,
  output logic                        apply_ex_o,
  output logic                        ram_we_c_o,
  output logic [WIDTH_CLAUSES-1:0]    ram_din_c_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_c_o,
  output logic                        ram_we_v_o,
  output logic [WIDTH_VAR-1:0]        ram_din_v_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_v_o,
  output logic                        ram_we_vs_o,
  output logic [WIDTH_VAR_STATES-1:0] ram_din_vs_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_vs_o,
  output logic                        ram_we_ls_o,
  output logic [WIDTH_LVL_STATES-1:0] ram_din_ls_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_ls_o,
  output logic                        start_o,
  output logic                        bin_info_en_o,
  output logic [WIDTH_CLAUSES-1:0]    nb_all_o,
  output logic [WIDTH_VAR-1:0]        nv_all_o,
  input  logic                        sb_done_i,
  input  logic                        sb_sat_i,
  input  logic                        sb_unsat_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        sat_o,
  output logic                        unsat_o,
  output logic                        err_o
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  // Largest usable RAM address; totals above this cannot be loaded.
  localparam logic [63:0] AddrMax = (64'd1 << ADDR_WIDTH) - 64'd1;

  typedef enum logic [2:0] {
    StIdle, StClr, StLoad, StFlush, StStart, StRun, StReport
  } state_e;

  state_e                     state_q, state_d;
  logic [WIDTH_CLAUSES-1:0]   nb_q, nb_d;
  logic [WIDTH_VAR-1:0]       nv_q, nv_d;
  logic [CntW-1:0]            c_total_q, c_total_d, v_total_q, v_total_d;
  logic [CntW-1:0]            c_cnt_q, c_cnt_d, v_cnt_q, v_cnt_d;
  logic                       sb_rst_n_q, sb_rst_n_d;
  logic                       apply_ex_q, apply_ex_d;
  logic                       c_ready_q, c_ready_d, v_ready_q, v_ready_d;
  logic                       we_c_q, we_c_d, we_v_q, we_v_d;
  logic [WIDTH_CLAUSES-1:0]   din_c_q, din_c_d;
  logic [WIDTH_VAR-1:0]       din_v_q, din_v_d;
  logic [ADDR_WIDTH-1:0]      addr_c_q, addr_c_d, addr_v_q, addr_v_d;
  logic                       start_q, start_d;
  logic [WIDTH_CLAUSES-1:0]   nb_all_q, nb_all_d;
  logic [WIDTH_VAR-1:0]       nv_all_q, nv_all_d;
  logic                       busy_q, busy_d, done_q, done_d;
  logic                       sat_q, sat_d, unsat_q, unsat_d, err_q, err_d;
  logic [63:0]                c_prod, v_prod;
  logic                       hs_c, hs_v;
  logic                       wdog_fire;

`ifdef SAT_BIN_LOAD_WATCHDOG_EN
  logic [31:0] wdog_q, wdog_d;

  // Timeout fires on the WDOG_CYCLES-th cycle spent in LOAD or RUN.
  always_comb begin
    wdog_fire = 1'b0;
    if ((state_q == StLoad) || (state_q == StRun)) begin
      wdog_fire = ({1'b0, wdog_q} + 33'd1) >= 33'(WDOG_CYCLES);
    end
  end

  // Cycle counter restarts on every state change and only counts in LOAD and RUN.
  always_comb begin
    wdog_d = '0;
    if ((state_d == state_q) && ((state_q == StLoad) || (state_q == StRun))) begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  // Next-state logic; every output is then derived from the state being entered.
  always_comb begin
    state_d   = state_q;
    nb_d      = nb_q;
    nv_d      = nv_q;
    c_total_d = c_total_q;
    v_total_d = v_total_q;
    c_cnt_d   = c_cnt_q;
    v_cnt_d   = v_cnt_q;
    sat_d     = sat_q;
    unsat_d   = unsat_q;
    err_d     = err_q;
    din_c_d   = din_c_q;
    addr_c_d  = addr_c_q;
    din_v_d   = din_v_q;
    addr_v_d  = addr_v_q;
    nb_all_d  = nb_all_q;
    nv_all_d  = nv_all_q;

    c_prod = 64'(nb_i) * 64'(NUM_CLAUSES_A_BIN);
    v_prod = 64'(nb_i) * 64'(NUM_VARS_A_BIN);
    hs_c   = (state_q == StLoad) && c_valid_i && c_ready_q;
    hs_v   = (state_q == StLoad) && v_valid_i && v_ready_q;

    // Address 0 is reserved, so word n lands at address n+1.
    if (hs_c) begin
      din_c_d  = c_data_i;
      addr_c_d = ADDR_WIDTH'(c_cnt_q + CntW'(1));
      c_cnt_d  = c_cnt_q + CntW'(1);
    end
    if (hs_v) begin
      din_v_d  = v_data_i;
      addr_v_d = ADDR_WIDTH'(v_cnt_q + CntW'(1));
      v_cnt_d  = v_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          nb_d      = nb_i;
          nv_d      = nv_i;
          c_total_d = CntW'(c_prod);
          v_total_d = CntW'(v_prod);
          c_cnt_d   = '0;
          v_cnt_d   = '0;
          sat_d     = 1'b0;
          unsat_d   = 1'b0;
          err_d     = 1'b0;
          if ((nb_i == '0) || (c_prod > AddrMax) || (v_prod > AddrMax)) begin
            err_d   = 1'b1;
            state_d = StReport;
          end else begin
            state_d = StClr;
          end
        end
      end
      StClr: state_d = StLoad;
      StLoad: begin
        if ((c_cnt_q == c_total_q) && (v_cnt_q == v_total_q)) begin
          state_d = StFlush;
        end else if (wdog_fire) begin
          err_d   = 1'b1;
          state_d = StReport;
        end
      end
      StFlush: state_d = StStart;
      StStart: state_d = StRun;
      StRun: begin
        if (sb_done_i) begin
          sat_d   = sb_sat_i;
          unsat_d = sb_unsat_i;
          err_d   = sb_sat_i & sb_unsat_i;
          state_d = StReport;
        end else if (wdog_fire) begin
          err_d   = 1'b1;
          state_d = StReport;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A handshake in the cycle the watchdog aborts LOAD must not produce a write.
    we_c_d     = hs_c && (state_d == StLoad);
    we_v_d     = hs_v && (state_d == StLoad);
    sb_rst_n_d = !((state_d == StClr) || wdog_fire);
    apply_ex_d = (state_d == StLoad) || (state_d == StFlush);
    c_ready_d  = (state_d == StLoad) && (c_cnt_d < c_total_d);
    v_ready_d  = (state_d == StLoad) && (v_cnt_d < v_total_d);
    start_d    = (state_d == StStart);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StReport);
    if (start_d) begin
      nb_all_d = nb_q;
      nv_all_d = nv_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      nb_q       <= '0;
      nv_q       <= '0;
      c_total_q  <= '0;
      v_total_q  <= '0;
      c_cnt_q    <= '0;
      v_cnt_q    <= '0;
      sb_rst_n_q <= 1'b1;
      apply_ex_q <= 1'b0;
      c_ready_q  <= 1'b0;
      v_ready_q  <= 1'b0;
      we_c_q     <= 1'b0;
      we_v_q     <= 1'b0;
      din_c_q    <= '0;
      din_v_q    <= '0;
      addr_c_q   <= '0;
      addr_v_q   <= '0;
      start_q    <= 1'b0;
      nb_all_q   <= '0;
      nv_all_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      unsat_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nb_q       <= nb_d;
      nv_q       <= nv_d;
      c_total_q  <= c_total_d;
      v_total_q  <= v_total_d;
      c_cnt_q    <= c_cnt_d;
      v_cnt_q    <= v_cnt_d;
      sb_rst_n_q <= sb_rst_n_d;
      apply_ex_q <= apply_ex_d;
      c_ready_q  <= c_ready_d;
      v_ready_q  <= v_ready_d;
      we_c_q     <= we_c_d;
      we_v_q     <= we_v_d;
      din_c_q    <= din_c_d;
      din_v_q    <= din_v_d;
      addr_c_q   <= addr_c_d;
      addr_v_q   <= addr_v_d;
      start_q    <= start_d;
      nb_all_q   <= nb_all_d;
      nv_all_q   <= nv_all_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
      unsat_q    <= unsat_d;
      err_q      <= err_d;
    end
  end

  assign sb_rst_n_o    = sb_rst_n_q;
  assign apply_ex_o    = apply_ex_q;
  assign c_ready_o     = c_ready_q;
  assign v_ready_o     = v_ready_q;
  assign ram_we_c_o    = we_c_q;
  assign ram_din_c_o   = din_c_q;
  assign ram_addr_c_o  = addr_c_q;
  // Var, var-state and lvl-state RAMs are written in lockstep at the same address.
  assign ram_we_v_o    = we_v_q;
  assign ram_din_v_o   = din_v_q;
  assign ram_addr_v_o  = addr_v_q;
  assign ram_we_vs_o   = we_v_q;
  assign ram_din_vs_o  = '0;
  assign ram_addr_vs_o = addr_v_q;
  assign ram_we_ls_o   = we_v_q;
  assign ram_din_ls_o  = '0;
  assign ram_addr_ls_o = addr_v_q;
  assign start_o       = start_q;
  assign bin_info_en_o = start_q;
  assign nb_all_o      = nb_all_q;
  assign nv_all_o      = nv_all_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign sat_o         = sat_q;
  assign unsat_o       = unsat_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_sat_bin_load_ctrl.sv
// Testbench for sat_bin_load_ctrl: randomized clause/var streams checked against the
// expected RAM image, start/bin-info timing and result latching.
module tb_sat_bin_load_ctrl;
  localparam int NC  = 8;
  localparam int NVB = 8;
  localparam int WC  = 16;
  localparam int WV  = 12;
  localparam int WVS = 19;
  localparam int WLS = 11;
  localparam int AW  = 9;
  localparam int LOG = 1024;
`ifdef SAT_BIN_LOAD_WATCHDOG_EN
  localparam int MaxNb = 2;
`else
  localparam int MaxNb = 8;
`endif

  logic clk = 1'b0, rst = 1'b1, load_start_i = 1'b0;
  logic [WC-1:0] nb_i = '0, c_data_i = '0, ram_din_c_o, nb_all_o;
  logic [WV-1:0] nv_i = '0, v_data_i = '0, ram_din_v_o, nv_all_o;
  logic c_valid_i = 1'b0, v_valid_i = 1'b0, c_ready_o, v_ready_o;
  logic sb_rst_n_o, apply_ex_o, ram_we_c_o, ram_we_v_o, ram_we_vs_o, ram_we_ls_o;
  logic [AW-1:0] ram_addr_c_o, ram_addr_v_o, ram_addr_vs_o, ram_addr_ls_o;
  logic [WVS-1:0] ram_din_vs_o;
  logic [WLS-1:0] ram_din_ls_o;
  logic start_o, bin_info_en_o, busy_o, done_o, sat_o, unsat_o, err_o;
  logic sb_done_i = 1'b0, sb_sat_i = 1'b0, sb_unsat_i = 1'b0;

  sat_bin_load_ctrl #(
    .NUM_CLAUSES_A_BIN(NC), .NUM_VARS_A_BIN(NVB), .WIDTH_CLAUSES(WC), .WIDTH_VAR(WV),
    .WIDTH_VAR_STATES(WVS), .WIDTH_LVL_STATES(WLS), .ADDR_WIDTH(AW)
`ifdef SAT_BIN_LOAD_WATCHDOG_EN
    , .WDOG_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .rst(rst), .load_start_i(load_start_i), .nb_i(nb_i), .nv_i(nv_i),
    .c_valid_i(c_valid_i), .c_data_i(c_data_i), .c_ready_o(c_ready_o),
    .v_valid_i(v_valid_i), .v_data_i(v_data_i), .v_ready_o(v_ready_o),
    .sb_rst_n_o(sb_rst_n_o), .apply_ex_o(apply_ex_o),
    .ram_we_c_o(ram_we_c_o), .ram_din_c_o(ram_din_c_o), .ram_addr_c_o(ram_addr_c_o),
    .ram_we_v_o(ram_we_v_o), .ram_din_v_o(ram_din_v_o), .ram_addr_v_o(ram_addr_v_o),
    .ram_we_vs_o(ram_we_vs_o), .ram_din_vs_o(ram_din_vs_o), .ram_addr_vs_o(ram_addr_vs_o),
    .ram_we_ls_o(ram_we_ls_o), .ram_din_ls_o(ram_din_ls_o), .ram_addr_ls_o(ram_addr_ls_o),
    .start_o(start_o), .bin_info_en_o(bin_info_en_o), .nb_all_o(nb_all_o),
    .nv_all_o(nv_all_o), .sb_done_i(sb_done_i), .sb_sat_i(sb_sat_i),
    .sb_unsat_i(sb_unsat_i), .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o),
    .unsat_o(unsat_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Observed RAM write log and event counters, written only by the monitor.
  logic [AW-1:0] c_la [LOG];
  logic [WC-1:0] c_ld [LOG];
  logic [AW-1:0] v_la [LOG];
  logic [WV-1:0] v_ld [LOG];
  int cyc = 0, c_wr_n = 0, v_wr_n = 0, viol_n = 0, start_n = 0, rstp_n = 0, done_n = 0;
  int apply_n = 0, last_wr_cyc = 0, start_cyc = 0, done_cyc = 0;
  logic [WC-1:0] start_nb = '0;
  logic [WV-1:0] start_nv = '0;
  logic start_bie = 1'b0, start_apply = 1'b0;

  // Expected stream contents for the current load.
  logic [WC-1:0] exp_c [LOG];
  logic [WV-1:0] exp_v [LOG];

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (apply_ex_o) apply_n <= apply_n + 1;
    if (!sb_rst_n_o) rstp_n <= rstp_n + 1;
    if (done_o) begin done_n <= done_n + 1; done_cyc <= cyc; end
    if (start_o) begin
      start_n <= start_n + 1; start_cyc <= cyc; start_nb <= nb_all_o; start_nv <= nv_all_o;
      start_bie <= bin_info_en_o; start_apply <= apply_ex_o;
    end
    if (ram_we_c_o) begin
      c_la[c_wr_n % LOG] <= ram_addr_c_o; c_ld[c_wr_n % LOG] <= ram_din_c_o;
      c_wr_n <= c_wr_n + 1; last_wr_cyc <= cyc;
      if (!apply_ex_o) viol_n <= viol_n + 1;
    end
    if (ram_we_v_o || ram_we_vs_o || ram_we_ls_o) begin
      v_la[v_wr_n % LOG] <= ram_addr_v_o; v_ld[v_wr_n % LOG] <= ram_din_v_o;
      v_wr_n <= v_wr_n + 1; last_wr_cyc <= cyc;
      if (!(ram_we_v_o && ram_we_vs_o && ram_we_ls_o && apply_ex_o) ||
          ram_addr_vs_o != ram_addr_v_o || ram_addr_ls_o != ram_addr_v_o ||
          ram_din_vs_o != '0 || ram_din_ls_o != '0) viol_n <= viol_n + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input int n, input int mode);
    int gap, k;
    bit r;
    for (int i = 0; i < n; i++) begin
      gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      c_valid_i = 1'b0;
      repeat (gap) step();
      c_valid_i = 1'b1; c_data_i = exp_c[i];
      k = 0; r = 1'b0;
      while (!r && k < 300) begin
        @(negedge clk); r = c_ready_o; @(posedge clk); #1; k++;
      end
      if (!r) begin
        n_cmp++; n_bad++;
        $display("FAIL c_handshake: word %0d not accepted, ready=%0b required 1", i, r);
        c_valid_i = 1'b0;
        return;
      end
    end
    c_valid_i = 1'b0;
  endtask

  task automatic drive_v(input int n, input int mode);
    int gap, k;
    bit r;
    if (mode == 1) repeat (20) step();
    for (int i = 0; i < n; i++) begin
      gap = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      v_valid_i = 1'b0;
      repeat (gap) step();
      v_valid_i = 1'b1; v_data_i = exp_v[i];
      k = 0; r = 1'b0;
      while (!r && k < 300) begin
        @(negedge clk); r = v_ready_o; @(posedge clk); #1; k++;
      end
      if (!r) begin
        n_cmp++; n_bad++;
        $display("FAIL v_handshake: word %0d not accepted, ready=%0b required 1", i, r);
        v_valid_i = 1'b0;
        return;
      end
    end
    v_valid_i = 1'b0;
  endtask

  // A load_start_i request mid-load must be ignored.
  task automatic poke_ignored(input int mode);
    if (mode == 2) begin
      repeat (3) step();
      load_start_i = 1'b1; nb_i = '0;
      step();
      load_start_i = 1'b0;
    end
  endtask

  // Full load/solve transaction; mode 0 back-to-back, 1 throttled, 2 random, 3 never done.
  task automatic do_load(input int nb, input int nv, input int mode, input bit sat,
                         input bit unsat);
    int ctot, vtot, cb, vb, sb, rb, db, vib, k, bad_i, idx;
    ctot = nb * NC; vtot = nb * NVB;
    for (int i = 0; i < ctot; i++) exp_c[i] = WC'($urandom);
    for (int i = 0; i < vtot; i++) exp_v[i] = WV'($urandom);
    cb = c_wr_n; vb = v_wr_n; sb = start_n; rb = rstp_n; db = done_n; vib = viol_n;
    nb_i = WC'(nb); nv_i = WV'(nv); load_start_i = 1'b1;
    step();
    load_start_i = 1'b0; nb_i = WC'($urandom); nv_i = WV'($urandom);
    fork
      drive_c(ctot, mode);
      drive_v(vtot, mode);
      poke_ignored(mode);
    join
    k = 0;
    while (start_n == sb && k < 50) begin step(); k++; end
    n_cmp++;
    if (start_n == sb) begin
      n_bad++;
      $display("FAIL start_wait: start_o count %0d required %0d", start_n - sb, 1);
      rst = 1'b1; step(); step(); rst = 1'b0;
      return;
    end
    n_cmp++;
    if (c_wr_n - cb !== ctot) begin
      n_bad++; $display("FAIL c_count: writes %0d required %0d", c_wr_n - cb, ctot);
    end
    bad_i = -1;
    for (int i = 0; i < ctot; i++) begin
      idx = (cb + i) % LOG;
      if (bad_i < 0 && (c_la[idx] !== AW'(i + 1) || c_ld[idx] !== exp_c[i])) bad_i = i;
    end
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++; idx = (cb + bad_i) % LOG;
      $display("FAIL c_content: word %0d got addr %0d data %h, required addr %0d data %h",
               bad_i, c_la[idx], c_ld[idx], bad_i + 1, exp_c[bad_i]);
    end
    n_cmp++;
    if (v_wr_n - vb !== vtot) begin
      n_bad++; $display("FAIL v_count: writes %0d required %0d", v_wr_n - vb, vtot);
    end
    bad_i = -1;
    for (int i = 0; i < vtot; i++) begin
      idx = (vb + i) % LOG;
      if (bad_i < 0 && (v_la[idx] !== AW'(i + 1) || v_ld[idx] !== exp_v[i])) bad_i = i;
    end
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++; idx = (vb + bad_i) % LOG;
      $display("FAIL v_content: word %0d got addr %0d data %h, required addr %0d data %h",
               bad_i, v_la[idx], v_ld[idx], bad_i + 1, exp_v[bad_i]);
    end
    n_cmp++;
    if (viol_n - vib !== 0) begin
      n_bad++; $display("FAIL write_rules: violations %0d required 0", viol_n - vib);
    end
    n_cmp++;
    if (start_nb !== WC'(nb) || start_nv !== WV'(nv) || start_bie !== 1'b1 ||
        start_apply !== 1'b0) begin
      n_bad++;
      $display("FAIL bin_info: nb %0d nv %0d bie %0b apply %0b, required %0d %0d 1 0",
               start_nb, start_nv, start_bie, start_apply, nb, nv);
    end
    n_cmp++;
    if (start_cyc - last_wr_cyc !== 2) begin
      n_bad++;
      $display("FAIL start_timing: start %0d cycles after last write, required 2",
               start_cyc - last_wr_cyc);
    end
    n_cmp++;
    if (rstp_n - rb !== 1) begin
      n_bad++; $display("FAIL clr_pulse: low cycles %0d required 1", rstp_n - rb);
    end
`ifdef SAT_BIN_LOAD_WATCHDOG_EN
    if (mode == 3) begin
      k = 0;
      while (done_n == db && k < 200) begin step(); k++; end
      n_cmp++;
      if (done_cyc - start_cyc !== 101 || done_n - db !== 1) begin
        n_bad++;
        $display("FAIL wdog_timing: done %0d cycles after start (count %0d), required 101 (1)",
                 done_cyc - start_cyc, done_n - db);
      end
      n_cmp++;
      if ({err_o, sat_o, unsat_o} !== 3'b100 || rstp_n - rb !== 2) begin
        n_bad++;
        $display("FAIL wdog_result: err/sat/unsat %b low %0d, required 100 low 2",
                 {err_o, sat_o, unsat_o}, rstp_n - rb);
      end
      return;
    end
`endif
    repeat ($urandom_range(0, 4)) step();
    sb_done_i = 1'b1; sb_sat_i = sat; sb_unsat_i = unsat;
    step();
    sb_done_i = 1'b0; sb_sat_i = 1'b0; sb_unsat_i = 1'b0;
    k = 0;
    while (done_n == db && k < 20) begin step(); k++; end
    n_cmp++;
    if ({sat_o, unsat_o, err_o} !== {sat, unsat, sat & unsat}) begin
      n_bad++;
      $display("FAIL result: sat/unsat/err %b required %b", {sat_o, unsat_o, err_o},
               {sat, unsat, sat & unsat});
    end
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++; $display("FAIL idle_after: busy %0b done %0b required 0 0", busy_o, done_o);
    end
    step();
    n_cmp++;
    if (done_n - db !== 1) begin
      n_bad++; $display("FAIL done_pulse: pulses %0d required 1", done_n - db);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (sb_rst_n_o !== 1'b1 || {apply_ex_o, ram_we_c_o, ram_we_v_o, ram_we_vs_o, ram_we_ls_o,
        start_o, bin_info_en_o, busy_o, done_o, sat_o, unsat_o, err_o, c_ready_o,
        v_ready_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: sb_rst_n %0b apply %0b busy %0b start %0b, required 1 0 0 0",
               sb_rst_n_o, apply_ex_o, busy_o, start_o);
    end
    n_cmp++;
    if ({ram_din_c_o, ram_addr_c_o, ram_din_v_o, ram_addr_v_o, ram_din_vs_o, ram_addr_vs_o,
         ram_din_ls_o, ram_addr_ls_o, nb_all_o, nv_all_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: addr_c %0d addr_v %0d nb_all %0d, required all 0",
               ram_addr_c_o, ram_addr_v_o, nb_all_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    do_load(2, 10, 0, 1'b1, 1'b0);
  endtask

  task automatic test_throttled();
    do_load(2, 10, 1, 1'b0, 1'b1);
  endtask

  // sb_done_i in IDLE changes nothing; last result was unsat.
  task automatic test_ignored_done();
    int db;
    db = done_n;
    sb_done_i = 1'b1; sb_sat_i = 1'b1;
    repeat (3) step();
    sb_done_i = 1'b0; sb_sat_i = 1'b0;
    step();
    n_cmp++;
    if (done_n - db !== 0 || busy_o !== 1'b0 || {sat_o, unsat_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL ignored_done: pulses %0d busy %0b sat/unsat %b, required 0 0 01",
               done_n - db, busy_o, {sat_o, unsat_o});
    end
  endtask

  task automatic test_bad_nb(input int nb);
    int cb, vb, sb, rb, db, ab, k;
    cb = c_wr_n; vb = v_wr_n; sb = start_n; rb = rstp_n; db = done_n; ab = apply_n;
    nb_i = WC'(nb); nv_i = WV'($urandom); load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
    k = 0;
    while (done_n == db && k < 10) begin step(); k++; end
    step();
    n_cmp++;
    if (done_n - db !== 1 || {err_o, sat_o, unsat_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL bad_nb %0d: pulses %0d err/sat/unsat %b, required 1 100", nb,
               done_n - db, {err_o, sat_o, unsat_o});
    end
    n_cmp++;
    if (c_wr_n - cb + v_wr_n - vb + start_n - sb + rstp_n - rb + apply_n - ab !== 0) begin
      n_bad++;
      $display("FAIL bad_nb_quiet %0d: writes %0d starts %0d clr %0d apply %0d, required 0",
               nb, c_wr_n - cb + v_wr_n - vb, start_n - sb, rstp_n - rb, apply_n - ab);
    end
  endtask

  task automatic test_mid_reset();
    int cb, k;
    for (int i = 0; i < 16; i++) exp_c[i] = WC'($urandom);
    cb = c_wr_n;
    nb_i = WC'(2); nv_i = WV'(5); load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
    drive_c(5, 0);
    k = 0;
    while (c_wr_n - cb < 5 && k < 5) begin step(); k++; end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({apply_ex_o, ram_we_c_o, ram_we_v_o, start_o, busy_o, c_ready_o, sb_rst_n_o}
        !== 7'b0000001) begin
      n_bad++;
      $display("FAIL mid_reset: apply/we_c/we_v/start/busy/ready/rst_n %b required 0000001",
               {apply_ex_o, ram_we_c_o, ram_we_v_o, start_o, busy_o, c_ready_o, sb_rst_n_o});
    end
    n_cmp++;
    if (c_wr_n - cb !== 5) begin
      n_bad++; $display("FAIL partial_writes: got %0d required 5", c_wr_n - cb);
    end
    rst = 1'b0;
    step();
    do_load(2, 5, 0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_load(int'($urandom_range(1, MaxNb)), int'($urandom_range(0, 4095)), 2,
              1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_throttled();
    test_ignored_done();
    test_bad_nb(0);
    test_bad_nb(64);
    test_bad_nb(int'($urandom_range(65, 65535)));
    test_mid_reset();
    test_random();
`ifdef SAT_BIN_LOAD_WATCHDOG_EN
    do_load(1, 3, 3, 1'b0, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sat_bin_load_ctrl.md
Name: sat_bin_load_ctrl

Overview:
Sequencer that owns the external load ports of sat_bin. For each problem it:
- pulses the sat_bin local reset;
- streams clause and variable bin words from host FIFOs into the four sat_bin RAMs (clauses, vars, var states, lvl states);
- issues start with the bin info, then waits for done and latches the global SAT/UNSAT result for the host.

It replaces the hand-driven load/start sequence and sits between the host DMA FIFOs and sat_bin.

Parameters:
NUM_CLAUSES_A_BIN, 8, clause words per bin (cmax)
NUM_VARS_A_BIN, 8, var words per bin (vmax)
WIDTH_CLAUSES, 16, clause word width (2 bits per var)
WIDTH_VAR, 12, var index width; also width of nv
WIDTH_VAR_STATES, 19, var state word width
WIDTH_LVL_STATES, 11, lvl state word width
ADDR_WIDTH, 9, address width of all four sat_bin RAMs

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
load_start_i  in  1  one-cycle request to load and solve; sampled only in IDLE
nb_i  in  WIDTH_CLAUSES  number of bins, sampled with load_start_i
nv_i  in  WIDTH_VAR  number of variables, sampled with load_start_i
c_valid_i / c_data_i / c_ready_o  in/in/out  1/WIDTH_CLAUSES/1  clause word stream
v_valid_i / v_data_i / v_ready_o  in/in/out  1/WIDTH_VAR/1  var word stream
sb_rst_n_o  out  1  active-low local reset to sat_bin
apply_ex_o  out  1  gives external ports RAM ownership
ram_we_c_o / ram_din_c_o / ram_addr_c_o  out  1/WIDTH_CLAUSES/ADDR_WIDTH  clause RAM write
ram_we_v_o / ram_din_v_o / ram_addr_v_o  out  1/WIDTH_VAR/ADDR_WIDTH  var RAM write
ram_we_vs_o / ram_din_vs_o / ram_addr_vs_o  out  1/WIDTH_VAR_STATES/ADDR_WIDTH  var state write
ram_we_ls_o / ram_din_ls_o / ram_addr_ls_o  out  1/WIDTH_LVL_STATES/ADDR_WIDTH  lvl state write
start_o, bin_info_en_o  out  1  one-cycle start plus bin info strobe
nb_all_o / nv_all_o  out  WIDTH_CLAUSES/WIDTH_VAR  bin info, valid with bin_info_en_o
sb_done_i, sb_sat_i, sb_unsat_i  in  1  sat_bin done_o, global_sat_o, global_unsat_o
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle completion pulse
sat_o, unsat_o, err_o  out  1  result flags; held until the next load_start_i

Behaviour:
- Reset state: IDLE. sb_rst_n_o=1; all other outputs 0, including all data and address outputs.
- All outputs are registered.
- States: IDLE -> CLR -> LOAD -> FLUSH -> START -> RUN -> REPORT -> IDLE.
- IDLE, load_start_i=1:
  - latch nb and nv;
  - compute c_total = nb*NUM_CLAUSES_A_BIN and v_total = nb*NUM_VARS_A_BIN at ADDR_WIDTH+1 bits;
  - clear sat_o, unsat_o, err_o.
  - If nb=0, or c_total or v_total exceeds 2^ADDR_WIDTH-1: go to REPORT with err_o=1. sat_bin is never touched.
  - Otherwise go to CLR.
- CLR: exactly 1 cycle with sb_rst_n_o=0. Then LOAD.
- LOAD: apply_ex_o=1.
  - c_ready_o = (c_cnt < c_total); v_ready_o = (v_cnt < v_total).
  - Clause handshake (c_valid_i & c_ready_o): next cycle ram_we_c_o=1, ram_din_c_o=data, ram_addr_c_o=c_cnt+1; c_cnt increments.
  - Var handshake: next cycle ram_we_v_o, ram_we_vs_o and ram_we_ls_o are all 1, all three addresses = v_cnt+1, ram_din_v_o=data, ram_din_vs_o=0, ram_din_ls_o=0.
  - The two streams advance independently and may handshake in the same cycle.
  - Write enables are 0 in any cycle with no preceding handshake. Address 0 is never written.
  - When c_cnt=c_total and v_cnt=v_total: go to FLUSH.
- FLUSH: 1 cycle. All write enables 0, apply_ex_o still 1.
- START: 1 cycle. apply_ex_o=0; start_o=1 and bin_info_en_o=1; nb_all_o and nv_all_o hold the latched values.
- RUN: wait for sb_done_i=1. Latch sat_o=sb_sat_i and unsat_o=sb_unsat_i. If both are 1, set err_o=1. Then REPORT.
- REPORT: done_o=1 for 1 cycle, then IDLE.
- sb_done_i outside RUN is ignored. load_start_i outside IDLE is ignored.
- rst asserted mid-operation: return to IDLE next cycle with all write enables, apply_ex_o and start_o deasserted; partial load is discarded.

Optional Feature:
SAT_BIN_LOAD_WATCHDOG_EN
- Defined: parameter WDOG_CYCLES (default 65535). A 32-bit counter runs in LOAD and RUN and clears on each state entry. On reaching WDOG_CYCLES: pulse sb_rst_n_o low for 1 cycle, set err_o=1, go to REPORT.
- Undefined: no counter; LOAD and RUN wait indefinitely.

Test Plan:
- nb=2, nv=10, 16 clause and 16 var words presented back-to-back: clause addresses 1..16 and var/vs/ls addresses 1..16 written in order with vs/ls data 0; start_o pulses one cycle after FLUSH with nb_all_o=2, nv_all_o=10.
- Same load with c_valid_i toggling every other cycle and v_valid_i delayed 20 cycles: identical RAM contents, no extra writes, LOAD exits only after the last of both streams.
- sb_done_i=1 with sb_sat_i=1: done_o pulses once, sat_o=1, unsat_o=0, busy_o=0 afterwards; with sb_unsat_i=1 instead: unsat_o=1.
- nb=0, then nb=64 (c_total=512 > 511): err_o=1 and done_o pulse; no CLR, write or start activity.
- rst asserted after 5 clause writes, then a fresh load_start_i: sb_rst_n_o low pulse is seen, addresses restart at 1, full load completes.
- Watchdog build with WDOG_CYCLES=100 and sb_done_i never asserted: sb_rst_n_o pulses, err_o=1 and done_o pulse 100 cycles after entering RUN.
